// File: rtl/camera_step_controller.sv
// camera_step_controller: turns six raw push-buttons (plus an orbit enable) into one-hot camera step pulses with auto-repeat.
// Latency: press to first step pulse is DEBOUNCE_CYCLES + 3 cycles (2-flop sync, debounce, FSM, output register).
// Backpressure: none; step outputs are single-cycle strobes that the pose block must always accept.
module camera_step_controller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_RATE     = 24'd1000000,
  parameter logic [23:0] ORBIT_PERIOD    = 24'd2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_rot_left,
  input  logic       btn_rot_right,
  input  logic       orbit_en,
  output logic       step_left,
  output logic       step_right,
  output logic       step_up,
  output logic       step_down,
  output logic       step_rot_left,
  output logic       step_rot_right,
  output logic [1:0] mode
);

  // Bit order doubles as priority order: bit 0 (left) is the highest priority.
  // Opposing pairs sit on adjacent bits {0,1}, {2,3}, {4,5}.
  localparam int NBTN = 6;
  localparam int ROT_RIGHT = 5;

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_MANUAL = 2'd1;
  localparam logic [1:0] MODE_ORBIT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ORBIT = 2'd3
  } state_t;

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] sync1_q;
  logic [NBTN-1:0] sync2_q;
  logic [NBTN-1:0] deb_lvl;
  logic [NBTN-1:0] pressed;
  logic [NBTN-1:0] win_oh;
  logic            win_vld;

  state_t          state_q, state_d;
  logic [NBTN-1:0] dir_q, dir_d;
  logic [23:0]     rep_cnt_q, rep_cnt_d;
  logic [23:0]     orb_cnt_q, orb_cnt_d;
  logic [NBTN-1:0] step_q, step_d;
  logic [1:0]      mode_q, mode_d;

  assign btn_raw = {btn_rot_right, btn_rot_left, btn_down, btn_up, btn_right, btn_left};

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // One debouncer per button, each with its own mismatch run counter.
  for (genvar g = 0; g < NBTN; g++) begin : g_deb
    logic [15:0] cnt_q, cnt_d;
    logic        lvl_q, lvl_d;

    // Count consecutive cycles where the synchronized level disagrees with the accepted level;
    // accept the new level on the DEBOUNCE_CYCLES-th such cycle, clear the count on any agreeing cycle.
    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (sync2_q[g] != lvl_q) begin
        if (({1'b0, cnt_q} + 17'd1) >= {1'b0, DEBOUNCE_CYCLES}) begin
          lvl_d = sync2_q[g];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    end

    // Debounce state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign deb_lvl[g] = lvl_q;
  end

  // Opposing directions held together cancel each other out.
  assign pressed[0] = deb_lvl[0] & ~deb_lvl[1];
  assign pressed[1] = deb_lvl[1] & ~deb_lvl[0];
  assign pressed[2] = deb_lvl[2] & ~deb_lvl[3];
  assign pressed[3] = deb_lvl[3] & ~deb_lvl[2];
  assign pressed[4] = deb_lvl[4] & ~deb_lvl[5];
  assign pressed[5] = deb_lvl[5] & ~deb_lvl[4];

  // Lowest set bit is the highest-priority direction; isolate it as a one-hot winner.
  assign win_oh  = pressed & (~pressed + 6'd1);
  assign win_vld = |pressed;

  // Next state, timers and step pulse selection.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rep_cnt_d = rep_cnt_q;
    orb_cnt_d = orb_cnt_q;
    step_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_FIRST;
        end else if (orbit_en) begin
          state_d   = ST_ORBIT;
          orb_cnt_d = '0;
        end
      end
      ST_FIRST: begin
        if (win_vld) begin
          step_d    = win_oh;
          dir_d     = win_oh;
          rep_cnt_d = REPEAT_DELAY;
          state_d   = ST_HOLD;
        end else if (orbit_en) begin
          state_d   = ST_ORBIT;
          orb_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!win_vld) begin
          if (orbit_en) begin
            state_d   = ST_ORBIT;
            orb_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (win_oh != dir_q) begin
          // New direction restarts with its own first pulse; the old one is dropped silently.
          state_d = ST_FIRST;
        end else if (rep_cnt_q <= 24'd1) begin
          // This cycle's decrement reaches zero: repeat pulse and reload the repeat interval.
          step_d    = dir_q;
          rep_cnt_d = REPEAT_RATE;
        end else begin
          rep_cnt_d = rep_cnt_q - 24'd1;
        end
      end
      default: begin
        // ST_ORBIT: any manual winner takes over immediately.
        if (win_vld) begin
          state_d = ST_FIRST;
        end else if (!orbit_en) begin
          state_d = ST_IDLE;
        end else if (({1'b0, orb_cnt_q} + 25'd1) >= {1'b0, ORBIT_PERIOD}) begin
          step_d[ROT_RIGHT] = 1'b1;
          orb_cnt_d         = '0;
        end else begin
          orb_cnt_d = orb_cnt_q + 24'd1;
        end
      end
    endcase
  end

  // Mode reports the state the FSM was in, registered alongside the step pulses.
  always_comb begin
    case (state_q)
      ST_FIRST, ST_HOLD: mode_d = MODE_MANUAL;
      ST_ORBIT:          mode_d = MODE_ORBIT;
      default:           mode_d = MODE_IDLE;
    endcase
  end

  // FSM state, timers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dir_q     <= '0;
      rep_cnt_q <= '0;
      orb_cnt_q <= '0;
      step_q    <= '0;
      mode_q    <= MODE_IDLE;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      rep_cnt_q <= rep_cnt_d;
      orb_cnt_q <= orb_cnt_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
    end
  end

  assign step_left      = step_q[0];
  assign step_right     = step_q[1];
  assign step_up        = step_q[2];
  assign step_down      = step_q[3];
  assign step_rot_left  = step_q[4];
  assign step_rot_right = step_q[5];
  assign mode           = mode_q;

endmodule

// File: tb/tb_camera_step_controller.sv
// tb_camera_step_controller: drives directed and random button/orbit/reset activity into camera_step_controller.
// Latency: reference model predicts outputs after every rising edge; DUT is sampled 1 time unit later.
// Backpressure: none; the bench checks every cycle.
module tb_camera_step_controller;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam int OP = 5;

  localparam int PH_IDLE  = 0;
  localparam int PH_FIRST = 1;
  localparam int PH_HOLD  = 2;
  localparam int PH_ORBIT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] btn = '0;
  logic       orbit_en = 1'b0;
  logic       step_left, step_right, step_up, step_down, step_rot_left, step_rot_right;
  logic [1:0] mode;
  logic [5:0] dut_step;

  assign dut_step = {step_rot_right, step_rot_left, step_down, step_up, step_right, step_left};

  always #5 clk = ~clk;

  camera_step_controller #(
    .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_DELAY   (24'd10),
    .REPEAT_RATE    (24'd3),
    .ORBIT_PERIOD   (24'd5)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_left      (btn[0]),
    .btn_right     (btn[1]),
    .btn_up        (btn[2]),
    .btn_down      (btn[3]),
    .btn_rot_left  (btn[4]),
    .btn_rot_right (btn[5]),
    .orbit_en      (orbit_en),
    .step_left     (step_left),
    .step_right    (step_right),
    .step_up       (step_up),
    .step_down     (step_down),
    .step_rot_left (step_rot_left),
    .step_rot_right(step_rot_right),
    .mode          (mode)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw-sample history per button, debounced levels, and a scheduler
  // that keeps absolute cycle numbers for the next repeat and the orbit start.
  logic [D+1:0] m_hist [6];   // bit k = raw level sampled k edges ago
  logic [5:0]   m_deb;
  logic [5:0]   m_step;
  logic [1:0]   m_mode;
  int           m_phase;
  int           m_dir;
  int           m_next;
  int           m_ostart;
  int           m_t = 0;

  function automatic int winner(input logic [5:0] deb);
    for (int i = 0; i < 6; i++) begin
      if (deb[i] && !deb[i ^ 1]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 6; b++) m_hist[b] = '0;
    m_deb   = '0;
    m_step  = '0;
    m_mode  = 2'd0;
    m_phase = PH_IDLE;
    m_dir   = -1;
  endtask

  task automatic leave_manual();
    if (orbit_en) begin
      m_phase  = PH_ORBIT;
      m_ostart = m_t;
    end else begin
      m_phase = PH_IDLE;
    end
  endtask

  task automatic model_edge();
    int w;
    w = winner(m_deb);
    m_mode = (m_phase == PH_IDLE) ? 2'd0 : (m_phase == PH_ORBIT) ? 2'd2 : 2'd1;
    m_step = '0;
    case (m_phase)
      PH_IDLE: begin
        if (w >= 0) m_phase = PH_FIRST;
        else if (orbit_en) begin
          m_phase  = PH_ORBIT;
          m_ostart = m_t;
        end
      end
      PH_FIRST: begin
        if (w >= 0) begin
          m_step  = 6'b1 << w;
          m_dir   = w;
          m_next  = m_t + RD;
          m_phase = PH_HOLD;
        end else leave_manual();
      end
      PH_HOLD: begin
        if (w < 0) leave_manual();
        else if (w != m_dir) m_phase = PH_FIRST;
        else if (m_t == m_next) begin
          m_step = 6'b1 << w;
          m_next = m_t + RR;
        end
      end
      default: begin
        if (w >= 0) m_phase = PH_FIRST;
        else if (!orbit_en) m_phase = PH_IDLE;
        else if ((m_t - m_ostart) % OP == 0) m_step = 6'b100000;
      end
    endcase
    // Debounced level flips once the synchronized samples (2 edges old) have disagreed for D edges.
    for (int b = 0; b < 6; b++) begin
      m_hist[b] = {m_hist[b][D:0], btn[b]};
      if (m_hist[b][D+1:2] == {D{~m_deb[b]}}) m_deb[b] = ~m_deb[b];
    end
    m_t++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    check("step_vs_model", 32'(dut_step), 32'(m_step));
    check("mode_vs_model", 32'(mode), 32'(m_mode));
    check("step_onehot", 32'($countones(dut_step) <= 1), 32'd1);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_step", 32'(dut_step), 32'd0);
    check("reset_mode", 32'(mode), 32'd0);
  endtask

  int seen;
  int up_after;
  int left_seen;
  int b;

  initial begin
    model_reset();
    #2;
    assert_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // Held left: first pulse D+3 cycles after press, then every REPEAT_RATE after REPEAT_DELAY.
    btn[0] = 1'b1;
    for (int c = 0; c < 28; c++) begin
      tick();
      check("hold_left_pulse", 32'(step_left), 32'(c == 7 || c == 17 || (c >= 20 && (c - 20) % 3 == 0)));
      check("hold_left_mode", 32'(mode), (c >= 7) ? 32'd1 : 32'd0);
    end
    btn = '0;
    repeat (12) tick();

    // Short glitch on up never produces a pulse.
    btn[2] = 1'b1;
    repeat (3) tick();
    btn[2] = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      check("glitch_no_step", 32'(dut_step), 32'd0);
      check("glitch_mode", 32'(mode), 32'd0);
    end

    // Opposed rotation buttons cancel; adding down gives down pulses only.
    btn[4] = 1'b1;
    btn[5] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("opposed_no_step", 32'(dut_step), 32'd0);
    end
    btn[3] = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      check("opposed_only_down", 32'(dut_step & 6'b110111), 32'd0);
      if (step_down) seen++;
    end
    check("opposed_down_seen", 32'(seen >= 3), 32'd1);
    btn = '0;
    repeat (15) tick();

    // Orbit: rot_right every OP cycles, manual press takes over, fresh count afterwards.
    orbit_en = 1'b1;
    for (int c = 0; c < 22; c++) begin
      tick();
      check("orbit_pulse", 32'(step_rot_right), 32'(c > 0 && c % OP == 0));
    end
    btn[1] = 1'b1;
    repeat (25) tick();
    btn[1] = 1'b0;
    repeat (25) tick();
    orbit_en = 1'b0;
    repeat (5) tick();

    // Priority: adding left while up repeats switches to left and stops up.
    btn[2] = 1'b1;
    repeat (25) tick();
    btn[0] = 1'b1;
    left_seen = 0;
    up_after  = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (step_left) left_seen = 1;
      if (left_seen != 0 && step_up) up_after++;
    end
    check("prio_left_seen", 32'(left_seen), 32'd1);
    check("prio_up_stopped", 32'(up_after), 32'd0);
    btn = '0;
    repeat (15) tick();

    // Reset during hold: next down pulse needs a full debounce after release.
    btn[3] = 1'b1;
    repeat (15) tick();
    assert_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("rst_release_down", 32'(step_down), 32'(c == 7));
    end
    btn = '0;
    repeat (15) tick();

    // Random buttons, orbit enable and occasional resets against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = int'($urandom_range(0, 5));
        btn[b] = ~btn[b];
      end
      if ($urandom_range(0, 59) == 0) orbit_en = ~orbit_en;
      if ($urandom_range(0, 999) == 0) begin
        assert_reset();
        repeat ($urandom_range(1, 3)) tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
